// File: rtl/spectrum_frame_reader_pkg.sv
// spectrum_frame_reader_pkg: widths shared with the magnitude stage and the reader FSM encoding
package spectrum_frame_reader_pkg;

    localparam int SPEC_ADDR_W = 13;
    localparam int SPEC_DATA_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

endpackage

// File: rtl/spectrum_bank_ram.sv
// spectrum_bank_ram: simple dual-port synchronous RAM, one write port, registered read with 1-cycle latency
module spectrum_bank_ram
    import spectrum_frame_reader_pkg::*;
#(
    parameter int ADDR_W = SPEC_ADDR_W + 1,
    parameter int DATA_W = SPEC_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // write port and registered read port; contents are never cleared
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/spectrum_frame_reader.sv
// spectrum_frame_reader: ping-pong capture of magnitude frames and max-hold decimated readout
module spectrum_frame_reader
    import spectrum_frame_reader_pkg::*;
#(
    parameter int ADDR_W  = SPEC_ADDR_W,
    parameter int DATA_W  = SPEC_DATA_W,
    parameter int DECIM_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  wr_mag,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic               wr_valid,
    input  logic               rd_start,
    input  logic [DECIM_W-1:0] rd_decim,
    output logic [DATA_W-1:0]  m_data,
    output logic [ADDR_W-1:0]  m_bin,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               frame_ready,
    output logic               busy,
    output logic               overrun
);

    localparam int CW = ADDR_W + 1;

    logic [1:0]         state;
    logic               wb;
    logic [DECIM_W-1:0] d;
    logic [ADDR_W-1:0]  g;
    logic [ADDR_W-1:0]  ra;
    logic [CW-1:0]      iss;
    logic [CW-1:0]      n;
    logic [CW-1:0]      g_end;
    logic               a_v, a_first, a_last;
    logic               r_v, r_first, r_last;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  rdata;
    logic [DATA_W-1:0]  mx;
    logic               accept;
    logic               done;
    logic               issue;

    // group size, end of current group (one extra bit so the last group reaches 2^ADDR_W)
    assign n      = CW'(1) << d;
    assign g_end  = {1'b0, g} + n;
    assign accept = (state == ST_IDLE) && rd_start && frame_ready;
    assign done   = wr_valid && (wr_addr == {ADDR_W{1'b1}});
    assign issue  = (state == ST_ACCUM) && (iss != n);
    assign mx     = (r_first || rdata > acc) ? rdata : acc;

    // bank bit is the address MSB: writer owns bank wb, reader owns bank ~wb
    spectrum_bank_ram #(
        .ADDR_W(CW),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (wr_valid),
        .waddr({wb, wr_addr}),
        .wdata(wr_mag),
        .raddr({~wb, ra}),
        .rdata(rdata)
    );

    // frame completion: an accepting rd_start counts as busy so the locked bank never flips
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb          <= 1'b0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            overrun <= done && (busy || accept);
            if (done && !(busy || accept)) begin
                wb          <= ~wb;
                frame_ready <= 1'b1;
            end else if (accept) begin
                frame_ready <= 1'b0;
            end
        end
    end

    // readout FSM: address issue, read-return pipeline with max fold, then output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            d       <= '0;
            g       <= '0;
            ra      <= '0;
            iss     <= '0;
            a_v     <= 1'b0;
            a_first <= 1'b0;
            a_last  <= 1'b0;
            r_v     <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            acc     <= '0;
            m_data  <= '0;
            m_bin   <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        d     <= rd_decim;
                        busy  <= 1'b1;
                        g     <= '0;
                        iss   <= '0;
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    a_v     <= issue;
                    a_first <= (iss == '0);
                    a_last  <= (iss == n - CW'(1));
                    if (issue) begin
                        ra  <= g + iss[ADDR_W-1:0];
                        iss <= iss + CW'(1);
                    end
                    r_v     <= a_v;
                    r_first <= a_first;
                    r_last  <= a_last;
                    if (r_v) acc <= mx;
                    if (r_v && r_last) begin
                        m_valid <= 1'b1;
                        m_data  <= mx;
                        m_bin   <= g;
                        m_last  <= g_end[ADDR_W];
                        state   <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        if (m_last) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            g     <= g_end[ADDR_W-1:0];
                            iss   <= '0;
                            state <= ST_ACCUM;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spectrum_frame_reader.sv
// tb_spectrum_frame_reader: table-driven readout scenarios with a scoreboard of expected beats
module tb_spectrum_frame_reader;
    import spectrum_frame_reader_pkg::*;

    localparam int AW = SPEC_ADDR_W;
    localparam int DW = SPEC_DATA_W;
    localparam int XW = 3;
    localparam int NB = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] wr_mag = '0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_valid = 1'b0;
    logic          rd_start = 1'b0;
    logic [XW-1:0] rd_decim = '0;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_bin;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic          frame_ready;
    logic          busy;
    logic          overrun;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] bin;
        logic          last;
    } beat_t;

    typedef struct {
        int d;
        bit bp;
        bit pre_full;
        int pre_pat;
        int bg;
        int bg_pat;
        bit same;
        int beats;
        int last_bin;
        int ovr;
        int lat;
    } vec_t;

    beat_t         sb[$];
    logic [DW-1:0] mem [2][NB];
    int            mwb = 0;
    bit            mfr = 1'b0;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            t0 = 0;
    int            exp_lat = 0;
    int            beats = 0;
    int            last_bin_seen = -1;
    int            ov_cnt = 0;
    bit            first_pend = 1'b0;
    bit            bp_en = 1'b0;
    bit            done_f = 1'b0;

    spectrum_frame_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_mag     (wr_mag),
        .wr_addr    (wr_addr),
        .wr_valid   (wr_valid),
        .rd_start   (rd_start),
        .rd_decim   (rd_decim),
        .m_data     (m_data),
        .m_bin      (m_bin),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .frame_ready(frame_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: cycle limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat_val(input int p, input int a);
        return p == 0 ? DW'(a) : p == 1 ? DW'(a % 11) : DW'($urandom);
    endfunction

    task automatic write_bin(input int a, input logic [DW-1:0] v, input bit is_busy);
        @(posedge clk);
        #1;
        wr_valid = 1'b1;
        wr_addr  = AW'(a);
        wr_mag   = v;
        mem[mwb][a] = v;
        if (a == NB - 1 && !is_busy) begin
            mwb ^= 1;
            mfr = 1'b1;
        end
    endtask

    task automatic write_end();
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic write_frame(input int p, input bit is_busy);
        for (int a = 0; a < NB; a++) write_bin(a, pat_val(p, a), is_busy);
        write_end();
    endtask

    task automatic write_single(input int p, input bit is_busy);
        write_bin(NB - 1, pat_val(p, NB - 1), is_busy);
        write_end();
    endtask

    task automatic push_expected(input int d);
        int n = 1 << d;
        int rb = mwb ^ 1;
        beat_t e;
        logic [DW-1:0] mx;
        for (int g = 0; g < NB; g += n) begin
            mx = mem[rb][g];
            for (int k = 1; k < n; k++) if (mem[rb][g + k] > mx) mx = mem[rb][g + k];
            e.data = mx;
            e.bin  = AW'(g);
            e.last = (g + n == NB);
            sb.push_back(e);
        end
    endtask

    task automatic start_read(input int d, input bit same, input logic [DW-1:0] v);
        push_expected(d);
        @(posedge clk);
        #1;
        rd_start = 1'b1;
        rd_decim = XW'(d);
        if (same) begin
            wr_valid = 1'b1;
            wr_addr  = '1;
            wr_mag   = v;
            mem[mwb][NB - 1] = v;
        end
        @(posedge clk);
        #1;
        t0 = cyc;
        first_pend = 1'b1;
        mfr = 1'b0;
        rd_start = 1'b0;
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done_f && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("readout_done", 32'(done_f), 32'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_m_bin"}, 32'(m_bin), 32'd0);
        check({tag, "_m_last"}, 32'(m_last), 32'd0);
        check({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        m_ready = bp_en ? ($urandom_range(3) != 0) : 1'b1;
    end

    initial begin
        beat_t e;
        bit prev_stall = 1'b0;
        logic [DW-1:0] pd;
        logic [AW-1:0] pb;
        logic pl;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_beat", 32'({m_data, m_bin, m_last}), 32'({pd, pb, pl}));
            end
            if (overrun) ov_cnt++;
            if (first_pend && m_valid) begin
                check("first_valid_latency", 32'(cyc - t0), 32'(exp_lat));
                first_pend = 1'b0;
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got bin 0x%0h data 0x%0h required no beat", m_bin, m_data);
                end else begin
                    e = sb.pop_front();
                    check("beat", 32'({m_data, m_bin, m_last}), 32'({e.data, e.bin, e.last}));
                    beats++;
                    if (e.last) begin
                        last_bin_seen = int'(m_bin);
                        done_f = 1'b1;
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            pd = m_data;
            pb = m_bin;
            pl = m_last;
        end
    end

    initial begin
        vec_t vt[4];
        int budget;
        int k;
        vt[0] = '{d:0, bp:0, pre_full:1, pre_pat:0, bg:1, bg_pat:1, same:0, beats:8192, last_bin:8191, ovr:1, lat:3};
        vt[1] = '{d:3, bp:0, pre_full:0, pre_pat:1, bg:1, bg_pat:2, same:0, beats:1024, last_bin:8184, ovr:1, lat:10};
        vt[2] = '{d:1, bp:1, pre_full:0, pre_pat:2, bg:2, bg_pat:2, same:0, beats:4096, last_bin:8190, ovr:2, lat:4};
        vt[3] = '{d:7, bp:0, pre_full:0, pre_pat:2, bg:0, bg_pat:2, same:1, beats:64, last_bin:8064, ovr:1, lat:130};

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_start = 1'b1;
        @(posedge clk);
        #1;
        rd_start = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("no_frame_busy", 32'(busy), 32'd0);
            check("no_frame_valid", 32'(m_valid), 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            ov_cnt = 0;
            beats = 0;
            done_f = 1'b0;
            last_bin_seen = -1;
            exp_lat = vt[i].lat;
            if (vt[i].pre_full) write_frame(vt[i].pre_pat, 1'b0);
            else write_single(vt[i].pre_pat, 1'b0);
            check("frame_ready_before", 32'(frame_ready), 32'(mfr));
            bp_en = vt[i].bp;
            start_read(vt[i].d, vt[i].same, DW'($urandom));
            budget = vt[i].beats * ((1 << vt[i].d) + 4) * 2 + 1000;
            fork
                for (int f = 0; f < vt[i].bg; f++) write_frame(vt[i].bg_pat, 1'b1);
                wait_done(budget);
            join
            bp_en = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("beat_count", 32'(beats), 32'(vt[i].beats));
            check("last_bin", 32'(last_bin_seen), 32'(vt[i].last_bin));
            check("overrun_pulses", 32'(ov_cnt), 32'(vt[i].ovr));
            check("frame_ready_after", 32'(frame_ready), 32'(mfr));
            check("busy_after", 32'(busy), 32'd0);
            check("scoreboard_left", 32'(sb.size()), 32'd0);
        end

        exp_lat = 3;
        beats = 0;
        done_f = 1'b0;
        write_single(2, 1'b0);
        check("frame_ready_before_reset", 32'(frame_ready), 32'(mfr));
        start_read(0, 1'b0, '0);
        k = 0;
        while (beats < 100 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("reached_beat_100", 32'(beats >= 100), 32'd1);
        rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        sb.delete();
        first_pend = 1'b0;
        mfr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_frame_ready", 32'(frame_ready), 32'(mfr));
        check("post_reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rd_start = 1'b1;
        @(posedge clk);
        #1;
        rd_start = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("post_reset_idle_busy", 32'(busy), 32'd0);
            check("post_reset_idle_valid", 32'(m_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
